sa_tile_sched: RTL and testbench

Tile scheduler that sequences the systolic-array wrapper through a full (M×K)·(K×N) matrix product, one SA_R×SA_C output tile at a time. It accepts a job by valid/ready handshake, pulses the array start, and waits for the array's output-valid. It then hands each finished tile to a downstream writeback consumer by valid/ready handshake, walks the tiles in row-major order, and signals job completion. It sits between the attention-layer control (job source) and the SA wrapper, which remains a single shared datapath.

---
 rtl/sa_sched_pkg.sv | 25 ++
 rtl/sa_sched_watchdog.sv | 29 ++
 rtl/sa_tile_sched.sv | 122 ++++++++++++
 tb/tb_sa_tile_sched.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_sched_pkg.sv
// Shared types and helpers for the systolic-array tile scheduler.
// Holds the scheduler state enum, field widths and the job legality check.
package sa_sched_pkg;

  localparam int unsigned SCHED_TILE_W = 4;
  localparam int unsigned M_DIM_W      = 8;
  localparam int unsigned WD_CNT_W     = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWait,
    StWb,
    StDone
  } sched_state_e;

  // A job is illegal if either tile count is zero or K is outside 1..max_k.
  function automatic logic job_illegal(input logic               m_zero,
                                       input logic               n_zero,
                                       input logic [M_DIM_W-1:0] k_dim,
                                       input logic [M_DIM_W-1:0] max_k);
    return m_zero || n_zero || (k_dim == '0) || (k_dim > max_k);
  endfunction

endpackage

// File: rtl/sa_sched_watchdog.sv
// WAIT-state watchdog for sa_tile_sched: counts WAIT cycles and flags expiry
// on the TIMEOUT-th one. Only instantiated when SA_SCHED_WATCHDOG_EN is defined.
module sa_sched_watchdog
  import sa_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam logic [WD_CNT_W-1:0] Limit = WD_CNT_W'(TIMEOUT - 1);

  logic [WD_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q <= '0;
    end else if (count_i && (cnt_q != Limit)) begin
      cnt_q <= cnt_q + WD_CNT_W'(1);
    end
  end

  assign expired_o = count_i && (cnt_q == Limit);

endmodule

// File: rtl/sa_tile_sched.sv
// Tile scheduler: walks an (M x K)*(K x N) product through the shared SA one
// output tile at a time, row-major. Optional watchdog: SA_SCHED_WATCHDOG_EN.
module sa_tile_sched
  import sa_sched_pkg::*;
#(
  parameter int unsigned SA_R    = 16,
  parameter int unsigned SA_C    = 16,
  parameter int unsigned MAX_K   = 128,
  parameter int unsigned TILE_W  = SCHED_TILE_W,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               I_CLK,
  input  logic               I_SYNC_RST,
  input  logic               I_JOB_VLD,
  output logic               O_JOB_RDY,
  input  logic [TILE_W-1:0]  I_JOB_M_TILES,
  input  logic [TILE_W-1:0]  I_JOB_N_TILES,
  input  logic [M_DIM_W-1:0] I_JOB_K_DIM,
  output logic               O_SA_START,
  output logic [M_DIM_W-1:0] O_SA_M_DIM,
  output logic [TILE_W-1:0]  O_TILE_ROW,
  output logic [TILE_W-1:0]  O_TILE_COL,
  input  logic               I_SA_OUT_VLD,
  output logic               O_WB_VLD,
  input  logic               I_WB_RDY,
  output logic               O_BUSY,
  output logic               O_JOB_DONE,
  output logic               O_ERR
);

  sched_state_e       state_q;
  logic [TILE_W-1:0]  m_tiles_q, n_tiles_q, row_q, col_q;
  logic [M_DIM_W-1:0] k_dim_q;
  logic               err_q;
  logic               illegal, last_row, last_col, wd_expired;
  logic               unused_cfg;

  assign illegal  = job_illegal(I_JOB_M_TILES == '0, I_JOB_N_TILES == '0, I_JOB_K_DIM,
                                M_DIM_W'(MAX_K));
  assign last_row = (row_q == m_tiles_q - TILE_W'(1));
  assign last_col = (col_q == n_tiles_q - TILE_W'(1));

`ifdef SA_SCHED_WATCHDOG_EN
  sa_sched_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i    (I_CLK),
    .rst_i    (I_SYNC_RST),
    .clear_i  (state_q == StStart),
    .count_i  (state_q == StWait),
    .expired_o(wd_expired)
  );
  assign unused_cfg = ^{SA_R, SA_C};
`else
  assign wd_expired = 1'b0;
  assign unused_cfg = ^{SA_R, SA_C, TIMEOUT};
`endif

  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST) begin
      state_q   <= StIdle;
      m_tiles_q <= '0;
      n_tiles_q <= '0;
      k_dim_q   <= '0;
      row_q     <= '0;
      col_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (I_JOB_VLD) begin
            m_tiles_q <= I_JOB_M_TILES;
            n_tiles_q <= I_JOB_N_TILES;
            k_dim_q   <= I_JOB_K_DIM;
            row_q     <= '0;
            col_q     <= '0;
            err_q     <= illegal;
            state_q   <= illegal ? StDone : StStart;
          end
        end
        StStart: state_q <= StWait;
        StWait: begin
          // A result in the expiry cycle still wins over the watchdog.
          if (I_SA_OUT_VLD) begin
            state_q <= StWb;
          end else if (wd_expired) begin
            err_q   <= 1'b1;
            state_q <= StDone;
          end
        end
        StWb: begin
          if (I_WB_RDY) begin
            if (last_row && last_col) begin
              state_q <= StDone;
            end else begin
              state_q <= StStart;
              if (last_col) begin
                col_q <= '0;
                row_q <= row_q + TILE_W'(1);
              end else begin
                col_q <= col_q + TILE_W'(1);
              end
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign O_JOB_RDY  = (state_q == StIdle);
  assign O_BUSY     = (state_q != StIdle);
  assign O_SA_START = (state_q == StStart);
  assign O_WB_VLD   = (state_q == StWb);
  assign O_JOB_DONE = (state_q == StDone);
  assign O_ERR      = err_q;
  assign O_SA_M_DIM = k_dim_q;
  assign O_TILE_ROW = row_q;
  assign O_TILE_COL = col_q;

endmodule

// File: tb/tb_sa_tile_sched.sv
// Self-checking bench for sa_tile_sched: per-cycle compare against a
// transaction-level model plus directed scenarios with literal expectations.
module tb_sa_tile_sched;

  localparam int unsigned TW = 4;
  localparam int unsigned TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          job_vld = 1'b0;
  logic [TW-1:0] job_m = '0;
  logic [TW-1:0] job_n = '0;
  logic [7:0]    job_k = '0;
  logic          sa_out_vld = 1'b0;
  logic          wb_rdy = 1'b0;
  logic          job_rdy, sa_start, wb_vld, busy, job_done, err;
  logic [7:0]    sa_m_dim;
  logic [TW-1:0] tile_row, tile_col;

  int vecs = 0;
  int miscmp = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  sa_tile_sched #(
    .SA_R   (16),
    .SA_C   (16),
    .MAX_K  (128),
    .TILE_W (TW),
    .TIMEOUT(TO)
  ) dut (
    .I_CLK        (clk),
    .I_SYNC_RST   (rst),
    .I_JOB_VLD    (job_vld),
    .O_JOB_RDY    (job_rdy),
    .I_JOB_M_TILES(job_m),
    .I_JOB_N_TILES(job_n),
    .I_JOB_K_DIM  (job_k),
    .O_SA_START   (sa_start),
    .O_SA_M_DIM   (sa_m_dim),
    .O_TILE_ROW   (tile_row),
    .O_TILE_COL   (tile_col),
    .I_SA_OUT_VLD (sa_out_vld),
    .O_WB_VLD     (wb_vld),
    .I_WB_RDY     (wb_rdy),
    .O_BUSY       (busy),
    .O_JOB_DONE   (job_done),
    .O_ERR        (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: expected outputs for the current cycle, advanced per edge.
  bit m_valid = 0, m_busy = 0, m_start = 0, m_wait = 0, m_wb = 0, m_done = 0, m_err = 0;
  int m_mdim = 0, m_row = 0, m_col = 0, m_wcnt = 0;
  int tq[$];

  always @(posedge clk) begin
    bit nstart, ndone;
    cyc++;
    nstart = 0;
    ndone  = 0;
    if (rst) begin
      m_valid = 1; m_busy = 0; m_wait = 0; m_wb = 0; m_err = 0;
      m_mdim = 0; m_row = 0; m_col = 0;
      tq.delete();
    end else if (m_valid) begin
      if (m_done) begin
        m_busy = 0;
      end else if (!m_busy) begin
        if (job_vld) begin
          m_busy = 1;
          m_err  = (job_m == 0) || (job_n == 0) || (job_k == 0) || (int'(job_k) > 128);
          m_mdim = int'(job_k);
          m_row  = 0;
          m_col  = 0;
          tq.delete();
          if (m_err) ndone = 1;
          else begin
            for (int r = 0; r < int'(job_m); r++)
              for (int c = 0; c < int'(job_n); c++) tq.push_back(r * 16 + c);
            nstart = 1;
          end
        end
      end else if (m_start) begin
        m_wait = 1;
        m_wcnt = 0;
      end else if (m_wait) begin
        if (sa_out_vld) begin
          m_wait = 0;
          m_wb   = 1;
        end else begin
          m_wcnt++;
`ifdef SA_SCHED_WATCHDOG_EN
          if (m_wcnt == TO) begin
            m_wait = 0;
            m_err  = 1;
            ndone  = 1;
          end
`endif
        end
      end else if (m_wb && wb_rdy) begin
        m_wb = 0;
        void'(tq.pop_front());
        if (tq.size() == 0) ndone = 1;
        else begin
          m_row  = tq[0] / 16;
          m_col  = tq[0] % 16;
          nstart = 1;
        end
      end
    end
    m_start = nstart;
    m_done  = ndone;
  end

  // Compare process plus event observers used by the directed checks.
  int start_cnt = 0, wb_cnt = 0, done_cyc = 0, vld_cyc = 0, last_start_cyc = 0;
  bit done_seen = 0, err_at_done = 0;
  int wb_log[$];

  always @(negedge clk) begin
    if (m_valid) begin
      chk("job_rdy", job_rdy, !m_busy);
      chk("busy", busy, m_busy);
      chk("sa_start", sa_start, m_start);
      chk("wb_vld", wb_vld, m_wb);
      chk("job_done", job_done, m_done);
      chk("err", err, m_err);
      chk("sa_m_dim", sa_m_dim, m_mdim);
      chk("tile_row", tile_row, m_row);
      chk("tile_col", tile_col, m_col);
    end
    if (sa_start) begin
      start_cnt++;
      last_start_cyc = cyc;
    end
    if (sa_out_vld) vld_cyc = cyc;
    if (wb_vld && wb_rdy) begin
      wb_cnt++;
      wb_log.push_back(int'(tile_row) * 16 + int'(tile_col));
    end
    if (job_done) begin
      done_seen   = 1;
      done_cyc    = cyc;
      err_at_done = err;
    end
  end

  // SA responder: fixed latency after start, or random noise in random mode.
  bit resp_on = 0, resp_rand = 0;
  int resp_lat = 4, resp_cnt = -1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (resp_rand) begin
        sa_out_vld = ($urandom_range(3) == 0);
      end else begin
        if (sa_start && resp_on) resp_cnt = resp_lat;
        else if (resp_cnt >= 0) resp_cnt--;
        sa_out_vld = (resp_cnt == 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int m, input int n, input int k);
    job_m   = TW'(m);
    job_n   = TW'(n);
    job_k   = 8'(k);
    job_vld = 1'b1;
    done_seen = 0;
    tick();
    job_vld = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done_seen && n < bound) begin
      tick();
      n++;
    end
    chk("done_within_bound", done_seen, 1);
    done_seen = 0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_job_rdy", job_rdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sa_start", sa_start, 0);
    chk("rst_wb_vld", wb_vld, 0);
    chk("rst_job_done", job_done, 0);
    chk("rst_err", err, 0);
    chk("rst_m_dim", sa_m_dim, 0);
    chk("rst_row", tile_row, 0);
    chk("rst_col", tile_col, 0);
  endtask

  initial begin
    int s0, w0, n;
    int exp_order[6];
    int ill_m[3], ill_n[3], ill_k[3];
    exp_order = '{0, 1, 2, 16, 17, 18};
    ill_m = '{1, 1, 0};
    ill_n = '{1, 1, 1};
    ill_k = '{0, 129, 16};

    tick();
    tick();
    rst = 1'b0;
    chk_reset_vals();

    // Single tile, SA answers 40 cycles after start.
    resp_on = 1; resp_lat = 40; wb_rdy = 1'b1;
    s0 = start_cnt;
    wb_log.delete();
    issue(1, 1, 16);
    chk("t1_start_t0p1", sa_start, 1);
    wait_done(200);
    chk("t1_starts", start_cnt - s0, 1);
    chk("t1_wb_count", wb_log.size(), 1);
    if (wb_log.size() > 0) chk("t1_wb_tile", wb_log[0], 0);
    chk("t1_done_lat", done_cyc - vld_cyc, 2);
    chk("t1_err", err_at_done, 0);

    // 2x3 tiles, K=128: row-major order.
    resp_lat = 5;
    s0 = start_cnt;
    wb_log.delete();
    issue(2, 3, 128);
    wait_done(500);
    chk("t2_starts", start_cnt - s0, 6);
    chk("t2_wb_count", wb_log.size(), 6);
    for (int i = 0; i < 6; i++) if (i < wb_log.size()) chk("t2_order", wb_log[i], exp_order[i]);
    chk("t2_m_dim", sa_m_dim, 128);

    // Backpressure: WB held 7 cycles.
    wb_rdy = 1'b0; resp_lat = 3;
    issue(1, 2, 8);
    n = 0;
    while (!wb_vld && n < 100) begin
      tick();
      n++;
    end
    chk("t3_wb_seen", wb_vld, 1);
    for (int i = 0; i < 7; i++) begin
      chk("t3_wb_hold", wb_vld, 1);
      chk("t3_row_hold", tile_row, 0);
      chk("t3_col_hold", tile_col, 0);
      chk("t3_no_start", sa_start, 0);
      tick();
    end
    wb_rdy = 1'b1;
    tick();
    chk("t3_start_after_hs", sa_start, 1);
    chk("t3_col_adv", tile_col, 1);
    wait_done(100);

    // Illegal jobs, then a legal one clears the error.
    for (int i = 0; i < 3; i++) begin
      s0 = start_cnt;
      issue(ill_m[i], ill_n[i], ill_k[i]);
      chk("t4_ill_done", job_done, 1);
      chk("t4_ill_err", err, 1);
      chk("t4_ill_nostart", sa_start, 0);
      tick();
      chk("t4_ill_starts", start_cnt - s0, 0);
      chk("t4_ill_rdy", job_rdy, 1);
    end
    issue(1, 1, 4);
    chk("t4_err_cleared", err, 0);
    chk("t4_legal_start", sa_start, 1);
    wait_done(100);

    // Reset while waiting on tile (1,0).
    resp_lat = 20;
    issue(2, 1, 16);
    n = 0;
    while (!(sa_start && tile_row == 1) && n < 200) begin
      tick();
      n++;
    end
    chk("t5_reached_1_0", tile_row, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals();
    done_seen = 0;
    tick(); tick(); tick();
    chk("t5_no_done", done_seen, 0);
    resp_lat = 4;
    wb_log.delete();
    issue(1, 1, 16);
    chk("t5_fresh_start", sa_start, 1);
    chk("t5_fresh_row", tile_row, 0);
    chk("t5_fresh_col", tile_col, 0);
    wait_done(100);
    chk("t5_wb_tile", (wb_log.size() == 1) ? wb_log[0] : -1, 0);

`ifdef SA_SCHED_WATCHDOG_EN
    // SA never answers: watchdog ends the job.
    resp_on = 0;
    w0 = wb_cnt;
    issue(1, 1, 16);
    wait_done(300);
    chk("t6_wait_cycles", done_cyc - last_start_cyc - 1, 64);
    chk("t6_err", err_at_done, 1);
    chk("t6_no_wb", wb_cnt - w0, 0);
    resp_on = 1;
`else
    w0 = wb_cnt;
`endif

    // Randomised traffic against the model.
    resp_rand = 1;
    for (int i = 0; i < 4000; i++) begin
      int r;
      job_vld = ($urandom_range(2) == 0);
      job_m   = ($urandom_range(9) == 0) ? TW'(0) : TW'($urandom_range(1, 3));
      job_n   = ($urandom_range(9) == 0) ? TW'(0) : TW'($urandom_range(1, 3));
      r = $urandom_range(19);
      job_k   = (r == 0) ? 8'd0 : (r == 1) ? 8'd129 : (r == 2) ? 8'd255
                                   : 8'($urandom_range(1, 128));
      wb_rdy  = ($urandom_range(2) != 0);
      rst     = ($urandom_range(399) == 0);
      tick();
    end
    rst = 1'b0;
    job_vld = 1'b0;
    tick();
    tick();
    chk("rand_wb_activity", (wb_cnt > w0) ? 1 : 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
